// File: rtl/bcd_disp_pkg.sv
// Shared constants for the 6-digit BCD display scanner.
// Segment codes are active-high {g,f,e,d,c,b,a}; polarity is applied at the top level.
package bcd_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  typedef enum logic [2:0] {
    DIG_MS_ONES  = 3'd0,
    DIG_MS_TENS  = 3'd1,
    DIG_MS_HUND  = 3'd2,
    DIG_SEC_ONES = 3'd3,
    DIG_SEC_TENS = 3'd4,
    DIG_MIN_ONES = 3'd5
  } digit_e;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Decimal points after sec_ones (sec.ms) and min_ones (min:sec).
  localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b101000;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_e d);
    return 6'b000001 << d;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern; codes 10-15 show a dash.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_disp_scan.sv
// Time-multiplexed 6-digit 7-segment scanner for the stopwatch M:SS.mmm BCD word.
// Optional leading-zero blanking of digits 5/4 when BCD_DISP_LZB_EN is defined.
module bcd_disp_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_bcd_time,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [5:0]  o_an
);

  localparam int unsigned        CNT_W    = $clog2(SCAN_DIV + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]         SEG_INV  = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic               DP_INV   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_INV = AN_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0] r_cnt;
  digit_e           r_idx;
  logic [23:0]      r_snap;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [5:0]       r_an;

  logic             w_tick;
  logic [3:0]       w_digit;
  logic [6:0]       w_dec;
  logic [6:0]       w_seg_hi;
  logic             w_dp_hi;

  assign w_tick  = (r_cnt == CNT_LAST);
  assign w_digit = r_snap[{r_idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  always_comb begin
    w_seg_hi = w_dec;
    w_dp_hi  = DP_MASK[r_idx];
`ifdef BCD_DISP_LZB_EN
    // Blanking looks at the snapshot, so it is stable for the whole frame.
    if ((r_idx == DIG_MIN_ONES && r_snap[23:20] == 4'd0) ||
        (r_idx == DIG_SEC_TENS && r_snap[23:16] == 8'd0)) begin
      w_seg_hi = SEG_BLANK;
      w_dp_hi  = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_idx  <= DIG_MS_ONES;
      r_snap <= '0;
      r_seg  <= SEG_INV;
      r_dp   <= DP_INV;
      r_an   <= AN_INV;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        if (r_idx == DIG_MIN_ONES) begin
          r_idx  <= DIG_MS_ONES;
          r_snap <= i_bcd_time;
        end else begin
          r_idx  <= digit_e'(r_idx + 3'd1);
        end
      end
      r_seg <= w_seg_hi ^ SEG_INV;
      r_dp  <= w_dp_hi ^ DP_INV;
      r_an  <= digit_onehot(r_idx) ^ AN_INV;
    end
  end

  assign o_seg = r_seg;
  assign o_dp  = r_dp;
  assign o_an  = r_an;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Self-checking bench: two scanners (SCAN_DIV=1 and 4) against a time-arithmetic reference model.
module tb_bcd_disp_scan;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [23:0] i_bcd_time = '0;

  logic [6:0]  seg1, seg4;
  logic        dp1, dp4;
  logic [5:0]  an1, an4;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  bcd_disp_scan #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_bcd_time(i_bcd_time),
    .o_seg(seg1), .o_dp(dp1), .o_an(an1)
  );

  bcd_disp_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_bcd_time(i_bcd_time),
    .o_seg(seg4), .o_dp(dp4), .o_an(an4)
  );

  // Model: count non-reset cycles t; slot = (t/D)%6, frame = t/(6D);
  // the snapshot is the input seen on the last cycle of the previous frame.
  int unsigned DIV   [2] = '{1, 4};
  int unsigned m_t   [2];
  logic [23:0] m_snap[2];
  logic [6:0]  e_seg [2];
  logic        e_dp  [2];
  logic [5:0]  e_an  [2];
  logic [6:0]  PAT   [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] exp_seg_hi(input int unsigned slot, input logic [23:0] sn);
    int unsigned d;
    d = (sn >> (4 * slot)) & 24'hF;
`ifdef BCD_DISP_LZB_EN
    if (slot == 5 && sn[23:20] == 4'd0) return 7'h00;
    if (slot == 4 && sn[23:16] == 8'd0) return 7'h00;
`endif
    if (d > 9) return 7'h40;
    return PAT[d];
  endfunction

  function automatic logic exp_dp_hi(input int unsigned slot, input logic [23:0] sn);
`ifdef BCD_DISP_LZB_EN
    if (slot == 5 && sn[23:20] == 4'd0) return 1'b0;
    if (slot == 4 && sn[23:16] == 8'd0) return 1'b0;
`endif
    return (slot == 3) || (slot == 5);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic rst_v, input logic [23:0] bcd_v);
    int unsigned slot;
    i_rst      = rst_v;
    i_bcd_time = bcd_v;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst_v) begin
        e_an[k]   = 6'h3F;
        e_seg[k]  = 7'h7F;
        e_dp[k]   = 1'b1;
        m_t[k]    = 0;
        m_snap[k] = '0;
      end else begin
        slot      = (m_t[k] / DIV[k]) % 6;
        e_an[k]   = ~(6'b000001 << slot);
        e_seg[k]  = ~exp_seg_hi(slot, m_snap[k]);
        e_dp[k]   = ~exp_dp_hi(slot, m_snap[k]);
        if (m_t[k] % (6 * DIV[k]) == 6 * DIV[k] - 1) m_snap[k] = bcd_v;
        m_t[k]++;
      end
    end
    #1;
    chk("an_div1",  {2'b0, an1},  {2'b0, e_an[0]});
    chk("seg_div1", {1'b0, seg1}, {1'b0, e_seg[0]});
    chk("dp_div1",  {7'b0, dp1},  {7'b0, e_dp[0]});
    chk("an_div4",  {2'b0, an4},  {2'b0, e_an[1]});
    chk("seg_div4", {1'b0, seg4}, {1'b0, e_seg[1]});
    chk("dp_div4",  {7'b0, dp4},  {7'b0, e_dp[1]});
  endtask

  function automatic logic [23:0] rand_bcd();
    logic [23:0] v;
    for (int j = 0; j < 6; j++) v[4*j +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  initial begin
    logic [23:0] v;
    // Reset held 3 cycles.
    for (int i = 0; i < 3; i++) cyc(1'b1, 24'h123456);
    // First frame shows zero, later frames 123456; switch mid-frame to 999999.
    for (int i = 0; i < 14; i++) cyc(1'b0, 24'h123456);
    for (int i = 0; i < 30; i++) cyc(1'b0, 24'h999999);
    // Invalid BCD dash on digit 0.
    for (int i = 0; i < 30; i++) cyc(1'b0, 24'h00000F);
    // Leading zeros, then a nonzero minute.
    for (int i = 0; i < 30; i++) cyc(1'b0, 24'h005123);
    for (int i = 0; i < 30; i++) cyc(1'b0, 24'h105123);
    // Mid-frame single-cycle reset, then resume.
    for (int i = 0; i < 3; i++) cyc(1'b0, 24'h105123);
    cyc(1'b1, 24'h105123);
    for (int i = 0; i < 30; i++) cyc(1'b0, 24'h987654);
    // Random phase: changing inputs, occasional resets, some leading zeros.
    for (int i = 0; i < 600; i++) begin
      v = rand_bcd();
      case ($urandom_range(3))
        0: v[23:16] = 8'h00;
        1: v[23:20] = 4'h0;
        2: if ($urandom_range(7) == 0) v = 24'($urandom);
        default: ;
      endcase
      cyc($urandom_range(60) == 0, v);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
